scr_pulse_monitor: RTL and testbench

Measures the debounced SCR firing pulse produced by the input de-glitch stage. Reports the last pulse high-time and rising-to-rising period in clock cycles, with a one-cycle valid strobe and a wrapping pulse count. Raises a sticky pulse-loss fault when no rising edge arrives within a timeout. Sits directly downstream of the pulse debouncer and feeds the protection/fault-reporting logic.

---
 rtl/scr_pulse_monitor.sv | 190 +++++++++++++++++++
 tb/tb_scr_pulse_monitor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr_pulse_monitor.sv
// SCR firing-pulse monitor: last high-time, rise-to-rise period, pulse count and sticky loss fault.
// Defining SCR_WIDTH_CHK_EN adds the MIN_WIDTH/MAX_WIDTH range check that drives width_flt.
module scr_pulse_monitor #(
  parameter int unsigned      CNT_W     = 24,
`ifdef SCR_WIDTH_CHK_EN
  parameter logic [CNT_W-1:0] MIN_WIDTH = 24'd50,
  parameter logic [CNT_W-1:0] MAX_WIDTH = 24'd5000,
`endif
  parameter logic [CNT_W-1:0] TIMEOUT   = 24'd2_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pulse_i,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] period_o,
  output logic             meas_vld,
  output logic [15:0]      pulse_cnt,
  output logic             loss_flt,
  output logic             width_flt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_HIGH      = 2'd2,
    S_LOW       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TMO_LAST = TIMEOUT - ONE;

  state_t           r_state, w_state_nxt;
  logic             r_pulse_d;
  logic [CNT_W-1:0] r_per_cnt, w_per_cnt_nxt;
  logic [CNT_W-1:0] r_wid_cnt, w_wid_cnt_nxt;
  logic [CNT_W-1:0] r_wid_lat, w_wid_lat_nxt;
  logic [CNT_W-1:0] r_width, w_width_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic             r_vld, w_vld_nxt;
  logic [15:0]      r_pcnt, w_pcnt_nxt;
  logic             r_loss, w_loss_set;
  logic             w_rise, w_fall, w_tmo;
`ifdef SCR_WIDTH_CHK_EN
  logic             r_wflt, w_wflt_set;
`endif

  assign w_rise = pulse_i & ~r_pulse_d;
  assign w_fall = ~pulse_i & r_pulse_d;
  assign w_tmo  = (r_per_cnt == TMO_LAST) & ~w_rise;

  // Next-state, counter and measurement-publish logic; en=0 overrides every state.
  always_comb begin
    w_state_nxt   = r_state;
    w_per_cnt_nxt = r_per_cnt;
    w_wid_cnt_nxt = r_wid_cnt;
    w_wid_lat_nxt = r_wid_lat;
    w_width_nxt   = r_width;
    w_period_nxt  = r_period;
    w_vld_nxt     = 1'b0;
    w_pcnt_nxt    = r_pcnt;
    w_loss_set    = 1'b0;
`ifdef SCR_WIDTH_CHK_EN
    w_wflt_set    = 1'b0;
`endif
    if (!en) begin
      w_state_nxt   = S_IDLE;
      w_per_cnt_nxt = ZERO;
      w_wid_cnt_nxt = ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_per_cnt_nxt = ZERO;
          w_wid_cnt_nxt = ZERO;
          w_state_nxt   = S_WAIT_RISE;
        end
        S_WAIT_RISE, S_LOW: begin
          if (w_rise) begin
            if (r_state == S_LOW) begin
              w_period_nxt = r_per_cnt;
              w_width_nxt  = r_wid_lat;
              w_vld_nxt    = 1'b1;
            end else begin
              w_vld_nxt    = 1'b0;
            end
            w_pcnt_nxt    = r_pcnt + 16'd1;
            w_per_cnt_nxt = ONE;
            w_wid_cnt_nxt = ONE;
            w_state_nxt   = S_HIGH;
          end else if (w_tmo) begin
            w_loss_set    = 1'b1;
            w_per_cnt_nxt = ZERO;
            w_state_nxt   = S_WAIT_RISE;
          end else begin
            w_per_cnt_nxt = r_per_cnt + ONE;
          end
        end
        S_HIGH: begin
          // A stuck-high input must still time out, so the timeout outranks a coincident fall.
          if (w_tmo) begin
            w_loss_set    = 1'b1;
            w_per_cnt_nxt = ZERO;
            w_state_nxt   = S_WAIT_RISE;
          end else begin
            w_per_cnt_nxt = r_per_cnt + ONE;
            w_wid_cnt_nxt = r_wid_cnt + ONE;
            if (w_fall) begin
              w_wid_lat_nxt = r_wid_cnt;
              w_state_nxt   = S_LOW;
`ifdef SCR_WIDTH_CHK_EN
              if ((r_wid_cnt < MIN_WIDTH) || (r_wid_cnt > MAX_WIDTH)) begin
                w_wflt_set = 1'b1;
              end else begin
                w_wflt_set = 1'b0;
              end
`endif
            end else begin
              w_state_nxt = S_HIGH;
            end
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_per_cnt_nxt = ZERO;
          w_wid_cnt_nxt = ZERO;
        end
      endcase
    end
  end

  // State, edge-detect, counter and output registers; sticky loss flag lets a set beat a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pulse_d <= 1'b0;
      r_per_cnt <= ZERO;
      r_wid_cnt <= ZERO;
      r_wid_lat <= ZERO;
      r_width   <= ZERO;
      r_period  <= ZERO;
      r_vld     <= 1'b0;
      r_pcnt    <= 16'd0;
      r_loss    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pulse_d <= pulse_i;
      r_per_cnt <= w_per_cnt_nxt;
      r_wid_cnt <= w_wid_cnt_nxt;
      r_wid_lat <= w_wid_lat_nxt;
      r_width   <= w_width_nxt;
      r_period  <= w_period_nxt;
      r_vld     <= w_vld_nxt;
      r_pcnt    <= w_pcnt_nxt;
      if (w_loss_set) begin
        r_loss <= 1'b1;
      end else if (clr_fault) begin
        r_loss <= 1'b0;
      end else begin
        r_loss <= r_loss;
      end
    end
  end

`ifdef SCR_WIDTH_CHK_EN
  // Sticky width-range fault, same set-over-clear priority as the loss flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wflt <= 1'b0;
    end else if (w_wflt_set) begin
      r_wflt <= 1'b1;
    end else if (clr_fault) begin
      r_wflt <= 1'b0;
    end else begin
      r_wflt <= r_wflt;
    end
  end
  assign width_flt = r_wflt;
`else
  assign width_flt = 1'b0;
`endif

  assign width_o   = r_width;
  assign period_o  = r_period;
  assign meas_vld  = r_vld;
  assign pulse_cnt = r_pcnt;
  assign loss_flt  = r_loss;

endmodule

// File: tb/tb_scr_pulse_monitor.sv
// Bench for scr_pulse_monitor: table-driven pulse trains, hand-written corner sequences,
// and randomized stimulus against an edge-index reference model.
module tb_scr_pulse_monitor;
  localparam int CNT_W = 24;
  localparam int TMO   = 1000;
`ifdef SCR_WIDTH_CHK_EN
  localparam bit WCHK = 1'b1;
`else
  localparam bit WCHK = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_HIGH = 2, PH_LOW = 3;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_vld;
    int exp_w;
    int exp_p;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n, en, pulse_i, clr_fault;
  logic [CNT_W-1:0] width_o, period_o;
  logic             meas_vld, loss_flt, width_flt;
  logic [15:0]      pulse_cnt;

  int n_chk = 0;
  int n_err = 0;
  int vld_seen = 0;

  // reference model state (edge indices rather than counters)
  int edge_n, m_ph, m_ref, m_rise, m_wid, m_width, m_period, m_cnt;
  bit m_vld, m_loss, m_wflt, m_prev;

  scr_pulse_monitor #(.CNT_W(CNT_W), .TIMEOUT(24'd1000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_i(pulse_i), .clr_fault(clr_fault),
    .width_o(width_o), .period_o(period_o), .meas_vld(meas_vld),
    .pulse_cnt(pulse_cnt), .loss_flt(loss_flt), .width_flt(width_flt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    edge_n = 0; m_ph = PH_IDLE; m_ref = 0; m_rise = 0; m_wid = 0;
    m_width = 0; m_period = 0; m_cnt = 0;
    m_vld = 1'b0; m_loss = 1'b0; m_wflt = 1'b0; m_prev = 1'b0;
  endtask

  // One clock edge of the reference: widths/periods are differences of sampled edge indices.
  task automatic m_step();
    bit p, rise, fall, set_l, set_w;
    p = (pulse_i === 1'b1);
    rise = p && !m_prev;
    fall = !p && m_prev;
    set_l = 1'b0;
    set_w = 1'b0;
    edge_n++;
    m_vld = 1'b0;
    if (en !== 1'b1) begin
      m_ph = PH_IDLE;
    end else if (m_ph == PH_IDLE) begin
      m_ph = PH_WAIT;
      m_ref = edge_n;
    end else if (rise && m_ph != PH_HIGH) begin
      if (m_ph == PH_LOW) begin
        m_period = edge_n - m_rise;
        m_width = m_wid;
        m_vld = 1'b1;
      end
      m_cnt = (m_cnt + 1) % 65536;
      m_rise = edge_n;
      m_ref = edge_n - 1;
      m_ph = PH_HIGH;
    end else if (edge_n - m_ref == TMO) begin
      set_l = 1'b1;
      m_ref = edge_n;
      m_ph = PH_WAIT;
    end else if (m_ph == PH_HIGH && fall) begin
      m_wid = edge_n - m_rise;
      set_w = WCHK && (m_wid < 50 || m_wid > 5000);
      m_ph = PH_LOW;
    end
    if (set_l) m_loss = 1'b1;
    else if (clr_fault === 1'b1) m_loss = 1'b0;
    if (set_w) m_wflt = 1'b1;
    else if (clr_fault === 1'b1) m_wflt = 1'b0;
    m_prev = p;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) m_reset();
      else m_step();
    end
  end

  // cycle-by-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (meas_vld === 1'b1) vld_seen++;
      chk("model_width_o", width_o, m_width);
      chk("model_period_o", period_o, m_period);
      chk("model_meas_vld", meas_vld, m_vld);
      chk("model_pulse_cnt", pulse_cnt, m_cnt);
      chk("model_loss_flt", loss_flt, m_loss);
      chk("model_width_flt", width_flt, m_wflt);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic hold(input bit p, input int n);
    pulse_i = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic rnd_hold(input bit p, input int n);
    pulse_i = p;
    repeat (n) begin
      clr_fault = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    clr_fault = 1'b0;
    en = 1'b1;
  endtask

  task automatic restart_en();
    en = 1'b0;
    pulse_i = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t tbl[4];
    int v0, c0, loss_t;
    tbl[0] = '{20, 80, 5, 4, 20, 100};
    tbl[1] = '{1, 1, 6, 5, 1, 2};
    tbl[2] = '{3, 7, 4, 3, 3, 10};
    tbl[3] = '{60, 40, 3, 2, 60, 100};

    rst_n = 1'b0; en = 1'b0; pulse_i = 1'b0; clr_fault = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_width_o", width_o, 0);
    chk("rst_period_o", period_o, 0);
    chk("rst_meas_vld", meas_vld, 0);
    chk("rst_pulse_cnt", pulse_cnt, 0);
    chk("rst_loss_flt", loss_flt, 0);
    chk("rst_width_flt", width_flt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      restart_en();
      v0 = vld_seen;
      c0 = m_cnt;
      repeat (tbl[i].reps) begin
        hold(1'b1, tbl[i].hi);
        hold(1'b0, tbl[i].lo);
      end
      chk($sformatf("tbl%0d_vld_count", i), vld_seen - v0, tbl[i].exp_vld);
      chk($sformatf("tbl%0d_width", i), width_o, tbl[i].exp_w);
      chk($sformatf("tbl%0d_period", i), period_o, tbl[i].exp_p);
      chk($sformatf("tbl%0d_pulse_cnt", i), pulse_cnt, (c0 + tbl[i].reps) % 65536);
      chk($sformatf("tbl%0d_loss", i), loss_flt, 0);
    end

    // 20/80 train, width check on first fall, then loss latency after the last rise
    clr_fault = 1'b1;
    restart_en();
    clr_fault = 1'b0;
    chk("wflt_clear_pre", width_flt, 0);
    v0 = vld_seen;
    hold(1'b1, 20);
    hold(1'b0, 1);
    chk("wflt_first_fall", width_flt, WCHK);
    hold(1'b0, 79);
    repeat (4) begin
      hold(1'b1, 20);
      hold(1'b0, 80);
    end
    chk("train_vld_count", vld_seen - v0, 4);
    chk("train_width", width_o, 20);
    chk("train_period", period_o, 100);
    chk("train_loss_none", loss_flt, 0);
    loss_t = -1;
    for (int t = 101; t <= 1200; t++) begin
      @(negedge clk);
      if (loss_flt === 1'b1 && loss_t < 0) loss_t = t;
    end
    chk("loss_latency", loss_t, 1000);
    v0 = vld_seen;
    repeat (2) begin
      hold(1'b1, 20);
      hold(1'b0, 80);
    end
    chk("resume_vld_count", vld_seen - v0, 1);
    chk("resume_width", width_o, 20);
    chk("resume_period", period_o, 100);

    // stuck-high timeouts; clear coincident with a timeout loses to the set
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    chk("stuck_loss_pre", loss_flt, 0);
    hold(1'b1, 1500);
    chk("stuck_loss_set", loss_flt, 1);
    hold(1'b1, 499);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    chk("stuck_set_wins", loss_flt, 1);
    hold(1'b0, 3);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    chk("stuck_clr_loss", loss_flt, 0);
    chk("stuck_clr_wflt", width_flt, 0);

    // en dropped mid-HIGH: outputs hold, first strobe only on second rise after re-enable
    restart_en();
    repeat (3) begin
      hold(1'b1, 30);
      hold(1'b0, 70);
    end
    hold(1'b1, 10);
    en = 1'b0;
    hold(1'b1, 5);
    en = 1'b1;
    v0 = vld_seen;
    hold(1'b1, 10);
    hold(1'b0, 60);
    hold(1'b1, 25);
    hold(1'b0, 75);
    chk("endrop_no_vld", vld_seen - v0, 0);
    chk("endrop_width_hold", width_o, 30);
    chk("endrop_period_hold", period_o, 100);
    hold(1'b1, 25);
    hold(1'b0, 75);
    chk("endrop_vld_second", vld_seen - v0, 1);
    chk("endrop_width_new", width_o, 25);
    chk("endrop_period_new", period_o, 100);

    // randomized trains, long gaps and stuck-high, random clears and enable dropouts
    for (int r = 0; r < 60; r++) begin
      rnd_hold(1'b1, (r % 20 == 13) ? 1100 : $urandom_range(1, 40));
      rnd_hold(1'b0, (r % 15 == 7) ? 1100 : $urandom_range(1, 150));
    end

    // reset mid-HIGH with three accepted rises
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    clr_fault = 1'b0;
    hold(1'b0, 2);
    repeat (2) begin
      hold(1'b1, 20);
      hold(1'b0, 80);
    end
    hold(1'b1, 5);
    chk("prerst_pulse_cnt", pulse_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_width_o", width_o, 0);
    chk("midrst_period_o", period_o, 0);
    chk("midrst_meas_vld", meas_vld, 0);
    chk("midrst_pulse_cnt", pulse_cnt, 0);
    chk("midrst_loss_flt", loss_flt, 0);
    chk("midrst_width_flt", width_flt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 3);
    repeat (2) begin
      hold(1'b1, 20);
      hold(1'b0, 80);
    end
    chk("postrst_pulse_cnt", pulse_cnt, 2);
    chk("postrst_width", width_o, 20);
    chk("postrst_period", period_o, 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
